// File: rtl/audio_test_capture.sv
// ---------------------------------------------------------------------------
// audio_test_capture
//
// Capture buffer that sits behind the audio processing top's test port. Each
// test_dout_valid strobe can store one 16-bit test word into an on-chip FIFO.
// Capture may be started immediately or on a rising edge of a selectable bit
// of the test word. The CPU drains the FIFO one byte at a time (LSB first).
//
// Ports:
//   clk              system clock, single domain
//   reset_n          synchronous active-low reset
//   test_dout_valid  one-cycle strobe, test word valid
//   test_data_out    test word
//   cap_control      [0] arm, [1] clear, [2] trig_en, [5:3] trig bit select
//   cap_rd_stb       one-cycle strobe, CPU consumed cap_rd_data
//   cap_rd_data      current byte of the head word (LSB first)
//   cap_status       [0] empty, [1] full, [2] waiting_trig, [3] capturing,
//                    [4] overflow, [5] byte_ptr, [7:6] zero
//   cap_word_cnt     number of words currently stored
// ---------------------------------------------------------------------------
module audio_test_capture #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              test_dout_valid,
  input  logic [DATA_W-1:0] test_data_out,
  input  logic [7:0]        cap_control,
  input  logic              cap_rd_stb,
  output logic [7:0]        cap_rd_data,
  output logic [7:0]        cap_status,
  output logic [ADDR_W:0]   cap_word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_FULL      = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   C_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t            r_state;
  logic              r_arm_d;
  logic              r_prev_bit;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_byte_ptr;
  logic              r_overflow;
  logic [7:0]        r_status;
  logic [7:0]        r_rd_data;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Control register fields
  logic              w_arm;
  logic              w_clear;
  logic              w_trig_en;
  logic [2:0]        w_trig_sel;
  logic [1:0]        w_unused_ctl;
  logic              w_trig_bit;

  // Per-cycle events
  logic              w_rd_accept;
  logic              w_pop;
  logic              w_trig;
  logic              w_wr_req;
  logic              w_room;
  logic              w_write;

  // Next-state values
  state_t            w_state_nxt;
  logic              w_prev_bit_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_byte_ptr_nxt;
  logic              w_ovf_nxt;
  logic [7:0]        w_status_nxt;

  assign w_arm        = cap_control[0];
  assign w_clear      = cap_control[1];
  assign w_trig_en    = cap_control[2];
  assign w_trig_sel   = cap_control[5:3];
  assign w_unused_ctl = cap_control[7:6];
  assign w_trig_bit   = test_data_out[w_trig_sel];

  // A read strobe on an empty FIFO is ignored entirely; a word is popped only
  // when the high byte has been consumed.
  assign w_rd_accept = cap_rd_stb && (r_count != '0);
  assign w_pop       = w_rd_accept && r_byte_ptr;

  // The triggering word itself is the first stored word.
  assign w_trig   = (r_state == S_WAIT_TRIG) && test_dout_valid && w_arm &&
                    !r_prev_bit && w_trig_bit;
  assign w_wr_req = w_trig ||
                    ((r_state == S_CAPTURE) && test_dout_valid && w_arm);

  // A pop in the same cycle frees the slot the write needs.
  assign w_room  = (r_count != C_DEPTH) || w_pop;
  assign w_write = reset_n && !w_clear && w_wr_req && w_room;

  // Next-state computation. Clear is applied last so it overrides arming,
  // writes and reads alike; memory contents are left untouched by it.
  always_comb begin
    w_state_nxt    = r_state;
    w_prev_bit_nxt = r_prev_bit;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;
    w_byte_ptr_nxt = r_byte_ptr;
    w_ovf_nxt      = r_overflow;

    if (w_write) begin
      w_wr_ptr_nxt = r_wr_ptr + C_PTR_ONE;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + C_PTR_ONE;
    end
    if (w_write && !w_pop) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (!w_write && w_pop) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end
    if (w_rd_accept) begin
      w_byte_ptr_nxt = !r_byte_ptr;
    end

    // Sticky overflow: strobes arriving after the buffer filled are lost.
    if (((r_state == S_FULL) && test_dout_valid && w_arm) ||
        (w_wr_req && !w_room)) begin
      w_ovf_nxt = 1'b1;
    end

    if (!w_arm) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_arm_d) begin
            if (w_trig_en) begin
              // Starting high means the level at arm time cannot trigger.
              w_state_nxt    = S_WAIT_TRIG;
              w_prev_bit_nxt = 1'b1;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (w_trig) begin
            w_state_nxt = (w_count_nxt == C_DEPTH) ? S_FULL : S_CAPTURE;
          end else if (test_dout_valid) begin
            w_prev_bit_nxt = w_trig_bit;
          end
        end
        S_CAPTURE: begin
          if (w_count_nxt == C_DEPTH) begin
            w_state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          w_state_nxt = S_FULL;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    if (w_clear) begin
      w_state_nxt    = S_IDLE;
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_byte_ptr_nxt = 1'b0;
      w_ovf_nxt      = 1'b0;
    end
  end

  // Status reflects the state being entered, so it appears one cycle after
  // the event that caused it, aligned with cap_word_cnt.
  assign w_status_nxt = {2'b00,
                         w_byte_ptr_nxt,
                         w_ovf_nxt,
                         (w_state_nxt == S_CAPTURE),
                         (w_state_nxt == S_WAIT_TRIG),
                         (w_count_nxt == C_DEPTH),
                         (w_count_nxt == '0)};

  // Capture memory and head-word register, kept free of reset so the array
  // maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= test_data_out;
    end
    r_head <= r_mem[r_rd_ptr];
  end

  // Control FSM, pointers and registered CPU-visible outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_arm_d    <= 1'b0;
      r_prev_bit <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_ptr <= 1'b0;
      r_overflow <= 1'b0;
      r_status   <= 8'h01;
      r_rd_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_arm_d    <= w_arm;
      r_prev_bit <= w_prev_bit_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_byte_ptr <= w_byte_ptr_nxt;
      r_overflow <= w_ovf_nxt;
      r_status   <= w_status_nxt;
      // Second pipeline stage of the read path: byte select from the head.
      if (r_count == '0) begin
        r_rd_data <= 8'h00;
      end else if (r_byte_ptr) begin
        r_rd_data <= r_head[15:8];
      end else begin
        r_rd_data <= r_head[7:0];
      end
    end
  end

  assign cap_rd_data  = r_rd_data;
  assign cap_status   = r_status;
  assign cap_word_cnt = r_count;

endmodule

// File: doc/audio_test_capture.md
Name: audio_test_capture

Overview:
- Capture buffer directly downstream of the audio processing top's test port (test_dout_valid / test_data_out[15:0]).
- Stores one 16-bit word per valid strobe into an on-chip FIFO, with optional bit-edge trigger.
- The CPU drains the FIFO byte-wise through its register interface, so FIR/EQ/mux debug streams can be inspected off-line at full audio rate.

Parameters:
ADDR_W, 9, FIFO address width; depth = 2^ADDR_W words (512).
DATA_W, 16, captured word width; fixed to match the test port.

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  synchronous, active-low reset
test_dout_valid  input  1  one-cycle strobe, test word valid
test_data_out  input  16  test word
cap_control  input  8  cpu reg: [0] arm, [1] clear, [2] trig_en, [5:3] trig_bit_sel (bit 0..7 of test word), [7:6] reserved
cap_rd_stb  input  1  one-cycle strobe, CPU has consumed cap_rd_data
cap_rd_data  output  8  current byte of head word (LSB first)
cap_status  output  8  cpu reg: [0] empty, [1] full, [2] waiting_trig, [3] capturing, [4] overflow, [5] byte_ptr, [7:6] 0
cap_word_cnt  output  ADDR_W+1  words currently stored (0..512)

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; wr_ptr, rd_ptr, count, byte_ptr, overflow = 0.
  - cap_rd_data=0x00; cap_status=0x01; cap_word_cnt=0.
- States:
  - IDLE: no writes.
    - Rising edge of arm (registered arm_d=0, arm=1) → WAIT_TRIG if trig_en=1, else CAPTURE.
  - WAIT_TRIG: on entry, prev_bit is set to 1.
    - On each valid strobe, sample b = test_data_out[trig_bit_sel].
    - If prev_bit=0 and b=1: write that word and go to CAPTURE. The triggering word is the first stored word.
    - Otherwise prev_bit <= b.
  - CAPTURE: every valid strobe writes mem[wr_ptr] and increments wr_ptr (wraps modulo 2^ADDR_W) and count.
    - If count reaches 2^ADDR_W → FULL.
  - FULL: one-shot; no further writes even after reads free space.
    - A valid strobe with arm=1 sets overflow (sticky).
    - Leaving FULL requires arm to be deasserted → IDLE, then re-armed.
  - arm=0 in any state → IDLE next cycle. Stored data and pointers are retained.
- clear=1 (level):
  - Each cycle: state=IDLE; pointers, count, byte_ptr and overflow = 0.
  - Highest priority over arm, write and read.
  - Memory contents are not cleared.
- Read side:
  - Head word is registered from mem[rd_ptr] (1-cycle RAM read).
  - cap_rd_data = head[7:0] when byte_ptr=0, head[15:8] when byte_ptr=1.
  - cap_rd_data is valid 2 cycles after any rd_ptr/byte_ptr change or after a write into an empty FIFO.
  - cap_rd_stb with count>0:
    - byte_ptr 0→1.
    - byte_ptr 1→0, rd_ptr+1 (wraps), count-1.
  - cap_rd_stb with count=0: ignored; byte_ptr unchanged; cap_rd_data=0x00 while empty.
- Simultaneous write and pop in the same cycle: count unchanged, both pointers advance.
- A write is accepted only if count<2^ADDR_W or a pop occurs in the same cycle. In FULL state, writes are never accepted.
- Status is registered, 1 cycle after the causing event:
  - empty = (count==0); full = (count==2^ADDR_W).
  - waiting_trig = (state==WAIT_TRIG); capturing = (state==CAPTURE).
- Reset mid-capture: all state returns to reset values on that edge; a valid strobe in the same cycle is dropped.

Test Plan:
1. Reset, then arm=1, trig_en=0; drive valid with words 0x0001..0x0005 → cap_word_cnt=5, status[3]=1. Ten cap_rd_stb reads → bytes 01,00,02,00,…,05,00, then empty=1, cap_rd_data=0x00.
2. trig_en=1, trig_bit_sel=2; feed words 0x0004, 0x0000, 0x0004, 0x1234 → first two not stored (level already high at arm, then low). Capture starts at the third word: FIFO holds 0x0004, 0x1234; count=2.
3. Arm without trigger and feed 520 valid words → count=512, status=0x12 after word 513 (full + overflow). Read 1 word → count=511 and no new writes while still in FULL.
4. During CAPTURE, a valid strobe coincides with a cap_rd_stb completing a word (byte_ptr=1) → count unchanged, wr_ptr and rd_ptr both +1. Read order is preserved across pointer wrap at 511→0.
5. Pulse clear=1 together with valid and arm=1 mid-capture → count=0, state IDLE, overflow=0, word dropped. arm must toggle 0→1 to restart.
6. Assert reset_n=0 for one cycle during CAPTURE with count=7 → all outputs return to reset values next cycle (cap_status=0x01, cap_word_cnt=0).
